fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. Owns the program counter, issues instruction-memory reads, and loads the IF/ID pipeline register. It sits directly downstream of the control unit: it consumes BranchEQ/BranchNE/Jump/JumpReg for the instruction in ID, plus the ALU Zero flag, and redirects the PC on taken branches and jumps. It squashes the wrong-path fetch, and it holds the memory address stable across a multi-cycle instruction-memory access.

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads, loads IF/ID, and
// redirects on taken branches/jumps resolved in ID (draining a busy fetch first).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        Zero,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpTarget,
  input  logic [31:0] RegJumpAddr,
  input  logic        Stall,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pending_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   pc4_q;
  logic              valid_q;

  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   jr_target;
  logic [XLEN-1:0]   j_target;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   target;
  logic              taken;
  logic              redirect;

  logic              imem_req;
  logic              load_fetch;
  logic              load_target;
  logic              load_pending;
  logic              load_drain;
  logic              clear_valid;
  logic              unused_bits;

  // Low target bits are dropped so the PC stays word-aligned.
  assign pc_plus4  = pc_q + XLEN'(4);
  assign jr_target = {RegJumpAddr[31:2], 2'b00};
  assign j_target  = {pc4_q[31:28], JumpTarget, 2'b00};
  assign br_target = pc4_q + {BranchOffset[29:0], 2'b00};

  always_comb begin
    target = br_target;
    if (JumpReg) begin
      target = jr_target;
    end else if (Jump) begin
      target = j_target;
    end
  end

  assign taken    = (BranchEQ & Zero) | (BranchNE & ~Zero) | Jump | JumpReg;
  assign redirect = (state_q == ST_RUN) & valid_q & ~Stall & taken;

  assign unused_bits = ^{RegJumpAddr[1:0], BranchOffset[31:30]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a redirect against a busy memory waits in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (redirect && !ImemReady) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ImemReady) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode: request line and datapath load strobes.
  always_comb begin
    imem_req     = ~reset;
    load_fetch   = 1'b0;
    load_target  = 1'b0;
    load_pending = 1'b0;
    load_drain   = 1'b0;
    clear_valid  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          clear_valid = 1'b1;
          if (ImemReady) begin
            load_target = 1'b1;
          end else begin
            load_pending = 1'b1;
          end
        end else if (!Stall) begin
          if (ImemReady) begin
            load_fetch = 1'b1;
          end else begin
            clear_valid = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        clear_valid = 1'b1;
        load_drain  = ImemReady;
      end
      default: clear_valid = 1'b1;
    endcase
  end

  // PC, pending target and IF/ID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pending_q <= '0;
      instr_q   <= '0;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (load_fetch) begin
        instr_q <= ImemRdata;
        pc4_q   <= pc_plus4;
        valid_q <= 1'b1;
        pc_q    <= pc_plus4;
      end else if (clear_valid) begin
        valid_q <= 1'b0;
      end
      if (load_target) begin
        pc_q <= target;
      end
      if (load_pending) begin
        pending_q <= target;
      end
      if (load_drain) begin
        pc_q <= pending_q;
      end
    end
  end

  assign ImemReq     = imem_req;
  assign ImemAddr    = pc_q;
  assign IF_ID_Instr = instr_q;
  assign IF_ID_PC4   = pc4_q;
  assign IF_ID_Valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts every cycle,
// a monitor compares; directed test-plan cases are followed by random traffic.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, BranchEQ, BranchNE, Jump, JumpReg, Zero, Stall, ImemReady;
  logic [31:0] BranchOffset, RegJumpAddr, ImemRdata;
  logic [25:0] JumpTarget;
  logic        ImemReq, IF_ID_Valid;
  logic [31:0] ImemAddr, IF_ID_Instr, IF_ID_PC4;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
    .Jump(Jump), .JumpReg(JumpReg), .Zero(Zero), .BranchOffset(BranchOffset),
    .JumpTarget(JumpTarget), .RegJumpAddr(RegJumpAddr), .Stall(Stall),
    .ImemReady(ImemReady), .ImemRdata(ImemRdata), .ImemReq(ImemReq),
    .ImemAddr(ImemAddr), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Stimulus staging, copied onto the DUT pins at the falling edge.
  logic        rst_s, rdy_s, stl_s, beq_s, bne_s, j_s, jr_s, z_s;
  logic [31:0] off_s, rja_s;
  logic [25:0] jt_s;

  // Reference model state: what the stage holds after the last rising edge.
  logic [31:0] m_pc, m_instr, m_pc4, m_pend;
  logic        m_valid, m_drain;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == RST_PC) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic clear();
    rst_s = 1'b0; rdy_s = 1'b0; stl_s = 1'b0; beq_s = 1'b0; bne_s = 1'b0;
    j_s = 1'b0; jr_s = 1'b0; z_s = 1'b0; off_s = '0; rja_s = '0; jt_s = '0;
  endtask

  task automatic model_step(input logic [31:0] rdata);
    logic        tk;
    logic [31:0] tgt;
    if (rst_s) begin
      m_pc = RST_PC; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_pend = '0; m_drain = 1'b0;
    end else if (m_drain) begin
      m_valid = 1'b0;
      if (rdy_s) begin
        m_pc = m_pend;
        m_drain = 1'b0;
      end
    end else begin
      tk = (beq_s && z_s) || (bne_s && !z_s) || j_s || jr_s;
      if (jr_s)     tgt = rja_s & 32'hFFFF_FFFC;
      else if (j_s) tgt = {m_pc4[31:28], 28'(jt_s) * 28'd4};
      else          tgt = m_pc4 + off_s * 32'd4;
      if (m_valid && !stl_s && tk) begin
        m_valid = 1'b0;
        if (rdy_s) m_pc = tgt;
        else begin
          m_pend = tgt;
          m_drain = 1'b1;
        end
      end else if (!stl_s) begin
        if (rdy_s) begin
          m_instr = rdata;
          m_pc4   = m_pc + 32'd4;
          m_pc    = m_pc + 32'd4;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] rd;
    @(negedge clk);
    rd = rdy_s ? mem(m_pc) : $urandom;
    reset = rst_s; ImemReady = rdy_s; Stall = stl_s; BranchEQ = beq_s;
    BranchNE = bne_s; Jump = j_s; JumpReg = jr_s; Zero = z_s;
    BranchOffset = off_s; RegJumpAddr = rja_s; JumpTarget = jt_s; ImemRdata = rd;
    model_step(rd);
    e.req = !rst_s; e.addr = m_pc; e.valid = m_valid; e.instr = m_instr; e.pc4 = m_pc4;
    sb.push_back(e);
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every rising edge with an outstanding prediction is compared.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("sb_req",   32'(ImemReq),     32'(mon_e.req));
      check("sb_addr",  ImemAddr,         mon_e.addr);
      check("sb_valid", 32'(IF_ID_Valid), 32'(mon_e.valid));
      check("sb_instr", IF_ID_Instr,      mon_e.instr);
      check("sb_pc4",   IF_ID_PC4,        mon_e.pc4);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d predictions pending", sb.size());
    $fatal(1);
  end

  initial begin
    logic [7:0] r8;
    m_pc = RST_PC; m_instr = '0; m_pc4 = '0; m_pend = '0; m_valid = 1'b0; m_drain = 1'b0;
    reset = 1'b1; ImemReady = 1'b0; Stall = 1'b0; BranchEQ = 1'b0; BranchNE = 1'b0;
    Jump = 1'b0; JumpReg = 1'b0; Zero = 1'b0; BranchOffset = '0; RegJumpAddr = '0;
    JumpTarget = '0; ImemRdata = '0;

    clear(); rst_s = 1'b1; rdy_s = 1'b1; tick(); tick(); post();
    check("rst_req", 32'(ImemReq), 32'd0);
    check("rst_addr", ImemAddr, RST_PC);
    check("rst_valid", 32'(IF_ID_Valid), 32'd0);

    clear(); rdy_s = 1'b1; tick(); post();
    check("first_instr", IF_ID_Instr, 32'h2008_0005);
    check("first_pc4", IF_ID_PC4, 32'h0040_0004);
    check("first_addr", ImemAddr, 32'h0040_0004);

    clear(); rdy_s = 1'b1; tick();
    clear(); rdy_s = 1'b1; beq_s = 1'b1; z_s = 1'b1; off_s = 32'hFFFF_FFFE; tick(); post();
    check("beq_taken_addr", ImemAddr, 32'h0040_0000);
    check("beq_taken_valid", 32'(IF_ID_Valid), 32'd0);

    clear(); rdy_s = 1'b1; tick(); tick();
    clear(); rdy_s = 1'b1; beq_s = 1'b1; off_s = 32'hFFFF_FFFE; tick(); post();
    check("beq_nt_addr", ImemAddr, 32'h0040_000C);
    check("beq_nt_valid", 32'(IF_ID_Valid), 32'd1);

    clear(); rdy_s = 1'b1; jr_s = 1'b1; j_s = 1'b1; rja_s = 32'h0040_0103; jt_s = 26'h3FF_FFFF;
    tick(); post();
    check("jr_prio_addr", ImemAddr, 32'h0040_0100);

    clear(); rdy_s = 1'b1; tick();
    clear(); rdy_s = 1'b1; jr_s = 1'b1; rja_s = 32'h0040_000C; tick();
    clear(); rdy_s = 1'b1; tick();
    clear(); rdy_s = 1'b1; j_s = 1'b1; jt_s = 26'h010_0040; tick(); post();
    check("j_addr", ImemAddr, 32'h0040_0100);

    clear(); rdy_s = 1'b1; tick();
    clear(); beq_s = 1'b1; z_s = 1'b1; off_s = 32'd4; tick(); post();
    check("drain0_addr", ImemAddr, 32'h0040_0104);
    for (int i = 0; i < 3; i++) begin
      clear(); jr_s = 1'b1; rja_s = $urandom; stl_s = 1'($urandom); tick(); post();
      check("drain_addr", ImemAddr, 32'h0040_0104);
      check("drain_valid", 32'(IF_ID_Valid), 32'd0);
    end
    clear(); rdy_s = 1'b1; tick(); post();
    check("drain_exit_addr", ImemAddr, 32'h0040_0114);

    clear(); rdy_s = 1'b1; tick();
    clear(); jr_s = 1'b1; rja_s = 32'h0050_0000; tick();
    clear(); tick();
    clear(); rst_s = 1'b1; tick(); post();
    check("drain_rst_addr", ImemAddr, RST_PC);
    clear(); rdy_s = 1'b1; tick(); post();
    check("drain_rst_run_addr", ImemAddr, 32'h0040_0004);
    check("drain_rst_run_valid", 32'(IF_ID_Valid), 32'd1);

    clear(); rdy_s = 1'b1; tick();
    for (int i = 0; i < 2; i++) begin
      clear(); rdy_s = 1'b1; stl_s = 1'b1; bne_s = 1'b1; off_s = 32'd8; tick(); post();
      check("stall_addr", ImemAddr, 32'h0040_0008);
      check("stall_pc4", IF_ID_PC4, 32'h0040_0008);
      check("stall_valid", 32'(IF_ID_Valid), 32'd1);
    end
    clear(); rdy_s = 1'b1; bne_s = 1'b1; off_s = 32'd8; tick(); post();
    check("unstall_bne_addr", ImemAddr, 32'h0040_0028);

    clear(); rdy_s = 1'b1; tick();
    clear(); rdy_s = 1'b1; jr_s = 1'b1; rja_s = 32'hFFFF_FFFB; tick();
    clear(); rdy_s = 1'b1; tick(); tick(); post();
    check("wrap_addr", ImemAddr, 32'h0000_0000);
    check("wrap_pc4", IF_ID_PC4, 32'h0000_0000);

    for (int i = 0; i < 3000; i++) begin
      clear();
      rst_s = ($urandom_range(99) == 0);
      rdy_s = ($urandom_range(9) < 7);
      stl_s = ($urandom_range(99) < 15);
      beq_s = ($urandom_range(9) == 0);
      bne_s = ($urandom_range(9) == 0);
      j_s   = ($urandom_range(19) == 0);
      jr_s  = ($urandom_range(19) == 0);
      z_s   = 1'($urandom);
      r8    = 8'($urandom);
      off_s = {{24{r8[7]}}, r8};
      jt_s  = 26'($urandom);
      rja_s = $urandom;
      tick();
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
